// File: rtl/svga_pkg.sv
// rtl/svga_pkg.sv - timing descriptors and standard modes for the SVGA timing generator
//
// Purpose : shared types for svga_timing_gen.
//   timing_t : one axis of a video mode (active, front porch, sync, back porch)
//   mode_t   : a full mode, horizontal and vertical timing
//   total()  : length of one axis period in pixels or lines
// Ports   : none (package)
package svga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  localparam mode_t SVGA_800x600_60 = '{
    h: '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
    v: '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
  };

  localparam mode_t VGA_640x480_60 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
  };

  function automatic int unsigned total(timing_t t);
    return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
  endfunction

endpackage

// File: rtl/svga_axis_counter.sv
// rtl/svga_axis_counter.sv - one wrapping timing axis (horizontal or vertical)
//
// Purpose : counts 0..TOTAL-1, advancing when adv is high, and decodes the
//           active and sync windows of that axis.
// Ports   :
//   clk      in   clock
//   reset    in   synchronous active-high reset, count returns to 0
//   adv      in   advance the count by one this cycle
//   count    out  current position on the axis
//   wrap     out  count is at TOTAL-1 (unqualified by adv)
//   active   out  count < ACTIVE
//   in_sync  out  count in [SYNC_START, SYNC_END)
module svga_axis_counter #(
  parameter int TOTAL      = 1056,
  parameter int SYNC_START = 840,
  parameter int SYNC_END   = 968,
  parameter int ACTIVE     = 800
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,
  output logic [$clog2(TOTAL)-1:0] count,
  output logic                     wrap,
  output logic                     active,
  output logic                     in_sync
);

  localparam int W = $clog2(TOTAL);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Window decodes are done at 32 bits so SYNC_END may equal TOTAL
  // (zero back porch) even when TOTAL is a power of two.
  always_comb begin
    wrap    = (count_q == W'(TOTAL - 1));
    active  = (32'(count_q) < 32'(ACTIVE));
    in_sync = (32'(count_q) >= 32'(SYNC_START)) && (32'(count_q) < 32'(SYNC_END));
    count_d = count_q;
    if (adv) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/svga_timing_gen.sv
// rtl/svga_timing_gen.sv - parametrised VGA/SVGA timing generator and pixel output stage
//
// Purpose : generates H/V counters, syncs, data-enable and line/frame strobes,
//           and blanks and registers the incoming pixel for the VGA pins.
// Ports   :
//   clk            in   clock
//   reset          in   synchronous active-high reset (priority over en)
//   en             in   1 = run, 0 = freeze counters, prescaler and outputs
//   rgb_in         in   {R,G,B} pixel for the current (x,y)
//   x, y           out  current horizontal / vertical count
//   pix_tick       out  counters advance this cycle
//   rgb_out        out  registered pixel, zero outside the active area
//   de             out  registered data-enable
//   hsync, vsync   out  registered syncs, polarity per HSYNC_POL / VSYNC_POL
//   next_vertical  out  last pixel tick of a line
//   next_frame     out  last pixel tick of a frame
module svga_timing_gen
  import svga_pkg::*;
#(
  parameter int H_ACTIVE   = int'(SVGA_800x600_60.h.active),
  parameter int H_FP       = int'(SVGA_800x600_60.h.fp),
  parameter int H_SYNC     = int'(SVGA_800x600_60.h.sync),
  parameter int H_BP       = int'(SVGA_800x600_60.h.bp),
  parameter int V_ACTIVE   = int'(SVGA_800x600_60.v.active),
  parameter int V_FP       = int'(SVGA_800x600_60.v.fp),
  parameter int V_SYNC     = int'(SVGA_800x600_60.v.sync),
  parameter int V_BP       = int'(SVGA_800x600_60.v.bp),
  parameter int HSYNC_POL  = 1,
  parameter int VSYNC_POL  = 1,
  parameter int COLOR_BITS = 2,
  parameter int PIXEL_REP  = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              en,
  input  logic [3*COLOR_BITS-1:0]                           rgb_in,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      y,
  output logic                                              pix_tick,
  output logic [3*COLOR_BITS-1:0]                           rgb_out,
  output logic                                              de,
  output logic                                              hsync,
  output logic                                              vsync,
  output logic                                              next_vertical,
  output logic                                              next_frame
);

  localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = int'(total(H_T));
  localparam int V_TOTAL = int'(total(V_T));
  localparam int PW      = (PIXEL_REP > 1) ? $clog2(PIXEL_REP) : 1;
  localparam int CW      = 3 * COLOR_BITS;
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_bad_width
    $error("svga_timing_gen: active and sync widths must be >= 1");
  end
  if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
    $error("svga_timing_gen: porches must be >= 0");
  end
  if (PIXEL_REP < 1) begin : g_bad_rep
    $error("svga_timing_gen: PIXEL_REP must be >= 1");
  end
  if (COLOR_BITS < 1) begin : g_bad_color
    $error("svga_timing_gen: COLOR_BITS must be >= 1");
  end

  logic [PW-1:0] p_q, p_d;
  logic          de_q, de_d;
  logic [CW-1:0] rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  logic h_wrap, h_active, h_in_sync;
  logic v_wrap, v_active, v_in_sync;

  // With PIXEL_REP=1 the prescaler stays at 0 and the compare is always true.
  assign pix_tick      = en & (p_q == PW'(PIXEL_REP - 1));
  assign next_vertical = pix_tick & h_wrap;
  assign next_frame    = next_vertical & v_wrap;

  svga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
    .ACTIVE     (H_ACTIVE)
  ) u_h (
    .clk     (clk),
    .reset   (reset),
    .adv     (pix_tick),
    .count   (x),
    .wrap    (h_wrap),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  // The vertical axis steps once per completed line.
  svga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
    .ACTIVE     (V_ACTIVE)
  ) u_v (
    .clk     (clk),
    .reset   (reset),
    .adv     (next_vertical),
    .count   (y),
    .wrap    (v_wrap),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  always_comb begin
    p_d     = p_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (en) begin
      p_d     = pix_tick ? '0 : p_q + 1'b1;
      de_d    = h_active & v_active;
      rgb_d   = de_d ? rgb_in : '0;
      hsync_d = h_in_sync ? HS_ON : ~HS_ON;
      vsync_d = v_in_sync ? VS_ON : ~VS_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
    end else begin
      p_q     <= p_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign de      = de_q;
  assign rgb_out = rgb_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;

endmodule

// File: tb/tb_svga_timing_gen.sv
// tb/tb_svga_timing_gen.sv - self-checking bench for svga_timing_gen
module tb_svga_timing_gen;
  import svga_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [5:0] rgb_in = '0;

  always #5 clk = ~clk;

  // Instance 0: tiny mode 16x8 totals, PIXEL_REP 1, positive syncs
  // Instance 1: default 800x600 parameters
  // Instance 2: 640x480 with PIXEL_REP 2, negative syncs
  wire [3:0]  x0;
  wire [2:0]  y0;
  wire [10:0] x1;
  wire [9:0]  y1;
  wire [9:0]  x2;
  wire [9:0]  y2;
  wire [2:0]  pix, de, hs, vs, nv, nf;
  wire [5:0]  rgb0, rgb1, rgb2;

  svga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_BITS(2), .PIXEL_REP(1)
  ) u_small (
    .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_in), .x(x0), .y(y0),
    .pix_tick(pix[0]), .rgb_out(rgb0), .de(de[0]), .hsync(hs[0]), .vsync(vs[0]),
    .next_vertical(nv[0]), .next_frame(nf[0])
  );

  svga_timing_gen u_def (
    .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_in), .x(x1), .y(y1),
    .pix_tick(pix[1]), .rgb_out(rgb1), .de(de[1]), .hsync(hs[1]), .vsync(vs[1]),
    .next_vertical(nv[1]), .next_frame(nf[1])
  );

  svga_timing_gen #(
    .H_ACTIVE(int'(VGA_640x480_60.h.active)), .H_FP(int'(VGA_640x480_60.h.fp)),
    .H_SYNC(int'(VGA_640x480_60.h.sync)), .H_BP(int'(VGA_640x480_60.h.bp)),
    .V_ACTIVE(int'(VGA_640x480_60.v.active)), .V_FP(int'(VGA_640x480_60.v.fp)),
    .V_SYNC(int'(VGA_640x480_60.v.sync)), .V_BP(int'(VGA_640x480_60.v.bp)),
    .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_BITS(2), .PIXEL_REP(2)
  ) u_vga (
    .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_in), .x(x2), .y(y2),
    .pix_tick(pix[2]), .rgb_out(rgb2), .de(de[2]), .hsync(hs[2]), .vsync(vs[2]),
    .next_vertical(nv[2]), .next_frame(nf[2])
  );

  logic [31:0] ax [3];
  logic [31:0] ay [3];
  logic [5:0]  argb [3];
  always_comb begin
    ax[0] = 32'(x0); ax[1] = 32'(x1); ax[2] = 32'(x2);
    ay[0] = 32'(y0); ay[1] = 32'(y1); ay[2] = 32'(y2);
    argb[0] = rgb0; argb[1] = rgb1; argb[2] = rgb2;
  end

  // Reference timing, written independently of the package constants.
  localparam int HA  [3] = '{8, 800, 640};
  localparam int HFP [3] = '{2, 40, 16};
  localparam int HSW [3] = '{3, 128, 96};
  localparam int HBP [3] = '{3, 88, 48};
  localparam int VA  [3] = '{4, 600, 480};
  localparam int VFP [3] = '{1, 1, 10};
  localparam int VSW [3] = '{2, 4, 2};
  localparam int VBP [3] = '{1, 23, 33};
  localparam int REP [3] = '{1, 1, 2};
  localparam int HP  [3] = '{1, 1, 0};
  localparam int VP  [3] = '{1, 1, 0};

  function automatic int ht(int i);
    return HA[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction
  function automatic int vt(int i);
    return VA[i] + VFP[i] + VSW[i] + VBP[i];
  endfunction

  // Model state: pixel ticks since reset and enabled clocks within the pixel.
  longint     tk [3];
  int         pre [3];
  bit         m_de [3], m_hs [3], m_vs [3];
  logic [5:0] m_rgb [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nv_cnt [3], nf_cnt [3], nv_last [3], nv_prev [3], nf_last [3], nf_prev [3];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input logic [5:0] c);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        tk[i] = 0; pre[i] = 0; m_de[i] = 0; m_rgb[i] = '0;
        m_hs[i] = (HP[i] == 0); m_vs[i] = (VP[i] == 0);
      end else if (e) begin
        int mx, my;
        mx = int'(tk[i] % ht(i));
        my = int'((tk[i] / ht(i)) % vt(i));
        m_de[i]  = (mx < HA[i]) && (my < VA[i]);
        m_rgb[i] = m_de[i] ? c : 6'h00;
        m_hs[i]  = ((mx >= HA[i] + HFP[i]) && (mx < HA[i] + HFP[i] + HSW[i])) ? (HP[i] != 0) : (HP[i] == 0);
        m_vs[i]  = ((my >= VA[i] + VFP[i]) && (my < VA[i] + VFP[i] + VSW[i])) ? (VP[i] != 0) : (VP[i] == 0);
        if (pre[i] == REP[i] - 1) begin
          pre[i] = 0;
          tk[i]++;
        end else begin
          pre[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int mx, my;
      bit mp, mnv, mnf;
      mx  = int'(tk[i] % ht(i));
      my  = int'((tk[i] / ht(i)) % vt(i));
      mp  = en && (pre[i] == REP[i] - 1);
      mnv = mp && (mx == ht(i) - 1);
      mnf = mnv && (my == vt(i) - 1);
      chk("x", i, ax[i], 32'(mx));
      chk("y", i, ay[i], 32'(my));
      chk("pix_tick", i, 32'(pix[i]), 32'(mp));
      chk("de", i, 32'(de[i]), 32'(m_de[i]));
      chk("rgb_out", i, 32'(argb[i]), 32'(m_rgb[i]));
      chk("hsync", i, 32'(hs[i]), 32'(m_hs[i]));
      chk("vsync", i, 32'(vs[i]), 32'(m_vs[i]));
      chk("next_vertical", i, 32'(nv[i]), 32'(mnv));
      chk("next_frame", i, 32'(nf[i]), 32'(mnf));
    end
  endtask

  // One clock: drive on the falling edge, note strobes of this cycle,
  // advance the model, then compare just after the rising edge.
  task automatic step(input bit r, input bit e, input logic [5:0] c);
    @(negedge clk);
    reset = r; en = e; rgb_in = c;
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (nv[i] === 1'b1) begin nv_prev[i] = nv_last[i]; nv_last[i] = cyc; nv_cnt[i]++; end
      if (nf[i] === 1'b1) begin nf_prev[i] = nf_last[i]; nf_last[i] = cyc; nf_cnt[i]++; end
    end
    model_edge(r, e, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [5:0] rgb;
    int         n;
    int         ex_x;
    int         ex_y;
    int         ex_nv;
    int         ex_nf;
  } seg_t;

  seg_t tbl [8];
  int   nv0, nf0, guard, cnt_vga_hs, cnt_def_hs, cnt_de, cnt_vs, rst_cyc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      nv_cnt[i] = 0; nf_cnt[i] = 0; nv_last[i] = 0; nv_prev[i] = 0; nf_last[i] = 0; nf_prev[i] = 0;
    end

    // Segments on the tiny instance (16 clocks per line, 8 lines per frame).
    tbl[0] = '{1'b1, 1'b0, 6'h3F,   2,  0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 6'h3F,   5,  5, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 6'h3F,  37,  5, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b1, 6'h15,  11,  0, 1, 1, 0};
    tbl[4] = '{1'b0, 1'b1, 6'h2A, 112,  0, 0, 7, 1};
    tbl[5] = '{1'b0, 1'b1, 6'h3F,  21,  5, 1, 1, 0};
    tbl[6] = '{1'b1, 1'b0, 6'h3F,   1,  0, 0, 0, 0};
    tbl[7] = '{1'b0, 1'b1, 6'h3F, 128,  0, 0, 8, 1};

    for (int s = 0; s < 8; s++) begin
      nv0 = nv_cnt[0];
      nf0 = nf_cnt[0];
      for (int k = 0; k < tbl[s].n; k++) step(tbl[s].rst, tbl[s].en, tbl[s].rgb);
      chk("seg_x", s, ax[0], 32'(tbl[s].ex_x));
      chk("seg_y", s, ay[0], 32'(tbl[s].ex_y));
      chk("seg_nv", s, 32'(nv_cnt[0] - nv0), 32'(tbl[s].ex_nv));
      chk("seg_nf", s, 32'(nf_cnt[0] - nf0), 32'(tbl[s].ex_nf));
    end

    // Randomised run: mostly enabled, random pixels, rare resets.
    for (int k = 0; k < 15000; k++) begin
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 7) != 0, 6'($urandom));
    end

    // Continuous run from reset: line/frame periods and sync widths.
    step(1'b1, 1'b0, 6'h3F);
    cnt_vga_hs = 0; cnt_def_hs = 0; cnt_de = 0; cnt_vs = 0;
    for (int k = 1; k <= 3300; k++) begin
      step(1'b0, 1'b1, 6'h3F);
      if (k <= 1600 && hs[2] === 1'b0) cnt_vga_hs++;
      if (k <= 1056 && hs[1] === 1'b1) cnt_def_hs++;
      if (k <= 128 && de[0] === 1'b1) cnt_de++;
      if (k <= 128 && vs[0] === 1'b1) cnt_vs++;
      if (k < 1056 && ax[1] == 32'd840) chk("hs_edge_840", 1, 32'(hs[1]), 32'd0);
      if (k < 1056 && ax[1] == 32'd841) chk("hs_edge_841", 1, 32'(hs[1]), 32'd1);
      if (k < 1056 && ax[1] == 32'd968) chk("hs_edge_968", 1, 32'(hs[1]), 32'd1);
      if (k < 1056 && ax[1] == 32'd969) chk("hs_edge_969", 1, 32'(hs[1]), 32'd0);
    end
    chk("def_line_clks", 1, 32'(nv_last[1] - nv_prev[1]), 32'd1056);
    chk("vga_line_clks", 2, 32'(nv_last[2] - nv_prev[2]), 32'd1600);
    chk("small_frame_clks", 0, 32'(nf_last[0] - nf_prev[0]), 32'd128);
    chk("vga_hsync_low_clks", 2, 32'(cnt_vga_hs), 32'd192);
    chk("def_hsync_high_clks", 1, 32'(cnt_def_hs), 32'd128);
    chk("small_de_per_frame", 0, 32'(cnt_de), 32'd32);
    chk("small_vsync_per_frame", 0, 32'(cnt_vs), 32'd32);

    // Freeze for 37 clocks at x=500 on the default instance.
    guard = 0;
    while (ax[1] != 32'd500 && guard < 1100) begin
      step(1'b0, 1'b1, 6'h3F);
      guard++;
    end
    chk("reach_x500", 1, ax[1], 32'd500);
    nv0 = nv_cnt[0] + nv_cnt[1] + nv_cnt[2];
    for (int k = 0; k < 37; k++) step(1'b0, 1'b0, 6'h3F);
    chk("frozen_x", 1, ax[1], 32'd500);
    chk("no_strobes_frozen", 1, 32'(nv_cnt[0] + nv_cnt[1] + nv_cnt[2]), 32'(nv0));
    nv0 = nv_cnt[1];
    guard = 0;
    while (nv_cnt[1] == nv0 && guard < 1200) begin
      step(1'b0, 1'b1, 6'h3F);
      guard++;
    end
    chk("stretched_line_clks", 1, 32'(nv_last[1] - nv_prev[1]), 32'd1093);

    // Mid-frame reset of the tiny instance, then time to the first frame strobe.
    for (int k = 0; k < 70; k++) step(1'b0, 1'b1, 6'h3F);
    step(1'b1, 1'b1, 6'h3F);
    rst_cyc = cyc;
    chk("rst_x", 0, ax[0], 32'd0);
    chk("rst_y", 0, ay[0], 32'd0);
    chk("rst_de", 0, 32'(de[0]), 32'd0);
    chk("rst_hsync", 0, 32'(hs[0]), 32'd0);
    chk("rst_vsync", 2, 32'(vs[2]), 32'd1);
    nf0 = nf_cnt[0];
    guard = 0;
    while (nf_cnt[0] == nf0 && guard < 200) begin
      step(1'b0, 1'b1, 6'h3F);
      guard++;
    end
    chk("first_frame_after_reset", 0, 32'(nf_last[0] - rst_cyc), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
